// File: rtl/mult_seq_ctrl.sv
// Sequencer for a 4x4-multiplier-based 8x8 multiply: four partial products, then done.
// Define MULT_SEQ_CTRL_ABORT_EN to add the abort input.
module mult_seq_ctrl #(
    parameter int unsigned DONE_PULSE = 0
) (
    input  logic       clk,
    input  logic       reset_a,
`ifdef MULT_SEQ_CTRL_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       done_flag,
    output logic       busy,
    output logic [2:0] state_out
);

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LSB  = 3'b001;
    localparam logic [2:0] S_MID  = 3'b010;
    localparam logic [2:0] S_MSB  = 3'b011;
    localparam logic [2:0] S_DONE = 3'b100;
    localparam logic [2:0] S_ERR  = 3'b101;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       run_q;
    logic       run_d;

    assign run_q = (state_q == S_LSB) || (state_q == S_MID) ||
                   (state_q == S_MSB);
    assign run_d = (state_d == S_LSB) || (state_d == S_MID) ||
                   (state_d == S_MSB);

    // Count only advances while staying inside the multiply run.
    assign cnt_d = (run_q && run_d) ? cnt_q + 2'd1 : 2'd0;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE: state_d = start ? S_LSB : S_IDLE;
            S_LSB:  state_d = start ? S_ERR : S_MID;
            S_MID: begin
                if (start)
                    state_d = S_ERR;
                else if (cnt_q == 2'd1)
                    state_d = S_MID;
                else
                    state_d = S_MSB;
            end
            S_MSB:  state_d = start ? S_ERR : S_DONE;
            S_DONE: begin
                if (start)
                    state_d = S_LSB;
                else if (DONE_PULSE != 0)
                    state_d = S_IDLE;
                else
                    state_d = S_DONE;
            end
            S_ERR:  state_d = start ? S_ERR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef MULT_SEQ_CTRL_ABORT_EN
        if (abort)
            state_d = S_IDLE;
`endif
    end

    always_comb begin
        input_sel = 2'b00;
        shift_sel = 2'd0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        done_flag = 1'b0;
        busy      = 1'b0;
        state_out = state_q;
        unique case (1'b1)
            run_q: begin
                input_sel = cnt_q;
                acc_en    = 1'b1;
                busy      = 1'b1;
                acc_clr   = (state_q == S_LSB);
                unique case (cnt_q)
                    2'd0:       shift_sel = 2'd0;
                    2'd1, 2'd2: shift_sel = 2'd1;
                    default:    shift_sel = 2'd2;
                endcase
            end
            (state_q == S_DONE): done_flag = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized bench for mult_seq_ctrl; both DONE_PULSE settings run side by side
// against a step-based reference model.
module tb_mult_seq_ctrl;

    logic clk;
    logic reset_a;
    logic start;
`ifdef MULT_SEQ_CTRL_ABORT_EN
    logic abort;
`endif

    logic [1:0] is0, ss0, is1, ss1;
    logic       clr0, en0, dn0, bz0, clr1, en1, dn1, bz1;
    logic [2:0] so0, so1;
    logic [10:0] outs0, outs1;

    int n_chk  = 0;
    int n_pass = 0;
    int m[2];

    assign outs0 = {so0, is0, ss0, clr0, en0, dn0, bz0};
    assign outs1 = {so1, is1, ss1, clr1, en1, dn1, bz1};

    mult_seq_ctrl #(.DONE_PULSE(0)) u_dut0 (
        .clk(clk), .reset_a(reset_a),
`ifdef MULT_SEQ_CTRL_ABORT_EN
        .abort(abort),
`endif
        .start(start), .input_sel(is0), .shift_sel(ss0),
        .acc_clr(clr0), .acc_en(en0), .done_flag(dn0),
        .busy(bz0), .state_out(so0)
    );

    mult_seq_ctrl #(.DONE_PULSE(1)) u_dut1 (
        .clk(clk), .reset_a(reset_a),
`ifdef MULT_SEQ_CTRL_ABORT_EN
        .abort(abort),
`endif
        .start(start), .input_sel(is1), .shift_sel(ss1),
        .acc_clr(clr1), .acc_en(en1), .done_flag(dn1),
        .busy(bz1), .state_out(so1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [10:0] obs,
                       input logic [10:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Model step: -1 idle, 0..3 partial product index, 4 done, 5 error.
    function automatic int nxt(input int s, input bit st, input bit ab,
                               input bit pulse);
        if (ab) return -1;
        if (s == 5) return st ? 5 : -1;
        if (s >= 0 && s <= 3) return st ? 5 : (s == 3 ? 4 : s + 1);
        if (s == 4) return st ? 0 : (pulse ? -1 : 4);
        return st ? 0 : -1;
    endfunction

    function automatic logic [10:0] exp_out(input int s);
        logic       act;
        logic [2:0] so;
        logic [1:0] isel, ssel;
        act  = (s >= 0 && s <= 3);
        if (s < 0)       so = 3'd0;
        else if (s == 0) so = 3'd1;
        else if (s <= 2) so = 3'd2;
        else if (s == 3) so = 3'd3;
        else if (s == 4) so = 3'd4;
        else             so = 3'd5;
        isel = act ? 2'(s) : 2'd0;
        ssel = act ? 2'((s + 1) / 2) : 2'd0;
        return {so, isel, ssel, s == 0, act, s == 4, act};
    endfunction

    task automatic tick(input bit st, input bit ab);
        start = st;
`ifdef MULT_SEQ_CTRL_ABORT_EN
        abort = ab;
`endif
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            m[i] = reset_a ? -1 : nxt(m[i], st, ab, i == 1);
        @(negedge clk);
        chk("dp0", outs0, exp_out(m[0]));
        chk("dp1", outs1, exp_out(m[1]));
        start = 1'b0;
`ifdef MULT_SEQ_CTRL_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    // Entered at a falling edge; reset lands mid low phase.
    task automatic async_reset();
        #3 reset_a = 1'b1;
        #1;
        chk("rst0", outs0, 11'd0);
        chk("rst1", outs1, 11'd0);
        m[0] = -1;
        m[1] = -1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold0", outs0, exp_out(-1));
        chk("rst_hold1", outs1, exp_out(-1));
        reset_a = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        reset_a = 1'b0;
        start   = 1'b0;
`ifdef MULT_SEQ_CTRL_ABORT_EN
        abort   = 1'b0;
`endif
        m[0] = -1;
        m[1] = -1;
        #1 reset_a = 1'b1;
        #1;
        chk("por0", outs0, 11'd0);
        chk("por1", outs1, 11'd0);
        @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;

        // single multiply, then long wait in DONE
        tick(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        // back-to-back from DONE, then error in MID
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        // reset while in MSB
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
`ifdef MULT_SEQ_CTRL_ABORT_EN
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
`endif

        for (int i = 0; i < 400; i++) begin
            bit st;
            bit ab;
            st = ($urandom_range(0, 3) == 0);
            ab = 1'b0;
`ifdef MULT_SEQ_CTRL_ABORT_EN
            ab = ($urandom_range(0, 9) == 0);
`endif
            if (i % 67 == 66)
                async_reset();
            else
                tick(st, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
